// File: rtl/spi_slave_regs_if.sv
// SPI pin bundle plus register-write / frame-status strobes of spi_slave_regs.
interface spi_slave_regs_if #(
    parameter int CMD_WIDTH  = 12,
    parameter int READ_WIDTH = 8
);
    localparam int ADDR_W = CMD_WIDTH - 1 - READ_WIDTH;

    logic                  sclk;
    logic                  cs;
    logic                  mosi;
    logic                  miso;
    logic                  miso_oe;
    logic                  wr_vld;
    logic [ADDR_W-1:0]     wr_addr;
    logic [READ_WIDTH-1:0] wr_data;
    logic                  rd_done;
    logic                  frame_err;

    modport master (
        output sclk, cs, mosi,
        input  miso, miso_oe, wr_vld, wr_addr, wr_data, rd_done, frame_err
    );

    modport slave (
        input  sclk, cs, mosi,
        output miso, miso_oe, wr_vld, wr_addr, wr_data, rd_done, frame_err
    );
endinterface

// File: rtl/spi_slave_regs.sv
// SPI mode-0 slave with an 8-entry register file: write frames store, header+data
// frame pairs read back a snapshot taken at the header.
module spi_slave_regs #(
    parameter int CMD_WIDTH  = 12,
    parameter int READ_WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_slave_regs_if.slave bus
);
    localparam int ADDR_W   = CMD_WIDTH - 1 - READ_WIDTH;
    localparam int NREGS    = 1 << ADDR_W;
    localparam int HDR_BITS = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, HDR, RD_PEND, RD_SHIFT} state_t;
    state_t state_q, state_d;

    logic sclk_p0, sclk_p1, sclk_p2;
    logic cs_p0, cs_p1, cs_p2;
    logic mosi_p0, mosi_p1;
    logic live_p0, live_p1;
    logic armed_q;

    logic [3:0]            bit_cnt;
    logic [CMD_WIDTH-1:0]  shift_q;
    logic [READ_WIDTH-1:0] tx_q;
    logic [READ_WIDTH-1:0] regs [NREGS];
    logic                  oe_q, wr_vld_q, rd_done_q, frame_err_q;
    logic [ADDR_W-1:0]     wr_addr_q;
    logic [READ_WIDTH-1:0] wr_data_q;

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic start_frame, do_write, do_snap, start_shift, end_read, rd_ok, err;

    // sclk edges only count while the synchronized cs is low
    assign sclk_rise = sclk_p1 & ~sclk_p2 & ~cs_p1;
    assign sclk_fall = ~sclk_p1 & sclk_p2 & ~cs_p1;
    assign cs_rise   = cs_p1 & ~cs_p2;
    assign cs_fall   = ~cs_p1 & cs_p2;

    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        do_write    = 1'b0;
        do_snap     = 1'b0;
        start_shift = 1'b0;
        end_read    = 1'b0;
        rd_ok       = 1'b0;
        err         = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall && armed_q) begin
                    state_d     = HDR;
                    start_frame = 1'b1;
                end
            end
            HDR: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    if (bit_cnt == 4'(CMD_WIDTH) && shift_q[CMD_WIDTH-1]) begin
                        do_write = 1'b1;
                    end else if (bit_cnt == 4'(HDR_BITS) && !shift_q[HDR_BITS-1]) begin
                        do_snap = 1'b1;
                        state_d = RD_PEND;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            RD_PEND: begin
                if (cs_fall) begin
                    state_d     = RD_SHIFT;
                    start_shift = 1'b1;
                end
            end
            RD_SHIFT: begin
                if (cs_rise) begin
                    state_d  = IDLE;
                    end_read = 1'b1;
                    if (bit_cnt == 4'(READ_WIDTH)) rd_ok = 1'b1;
                    else                           err   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_p0     <= 1'b0;
            sclk_p1     <= 1'b0;
            sclk_p2     <= 1'b0;
            cs_p0       <= 1'b1;
            cs_p1       <= 1'b1;
            cs_p2       <= 1'b1;
            mosi_p0     <= 1'b0;
            mosi_p1     <= 1'b0;
            live_p0     <= 1'b0;
            live_p1     <= 1'b0;
            armed_q     <= 1'b0;
            bit_cnt     <= '0;
            shift_q     <= '0;
            tx_q        <= '0;
            oe_q        <= 1'b0;
            wr_vld_q    <= 1'b0;
            rd_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            sclk_p0 <= bus.sclk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            cs_p0   <= bus.cs;
            cs_p1   <= cs_p0;
            cs_p2   <= cs_p1;
            mosi_p0 <= bus.mosi;
            mosi_p1 <= mosi_p0;
            // cs_p1 holds a real sample once live_p1 is set; a frame needs cs seen high first
            live_p0 <= 1'b1;
            live_p1 <= live_p0;
            armed_q <= armed_q | (live_p1 & cs_p1);

            wr_vld_q    <= do_write;
            rd_done_q   <= rd_ok;
            frame_err_q <= err;

            if (start_frame) begin
                bit_cnt <= '0;
                shift_q <= '0;
            end else if (state_q == HDR && sclk_rise) begin
                shift_q <= {shift_q[CMD_WIDTH-2:0], mosi_p1};
                if (bit_cnt != 4'hF) bit_cnt <= bit_cnt + 4'd1;
            end else if (start_shift) begin
                bit_cnt <= '0;
            end else if (state_q == RD_SHIFT && sclk_rise && bit_cnt != 4'hF) begin
                bit_cnt <= bit_cnt + 4'd1;
            end

            if (do_write) begin
                regs[shift_q[CMD_WIDTH-2 -: ADDR_W]] <= shift_q[READ_WIDTH-1:0];
                wr_addr_q <= shift_q[CMD_WIDTH-2 -: ADDR_W];
                wr_data_q <= shift_q[READ_WIDTH-1:0];
            end

            if (do_snap) begin
                tx_q <= regs[shift_q[ADDR_W-1:0]];
            end else if (state_q == RD_SHIFT && sclk_fall) begin
                tx_q <= {tx_q[READ_WIDTH-2:0], 1'b0};
            end

            if (start_shift)   oe_q <= 1'b1;
            else if (end_read) oe_q <= 1'b0;
        end
    end

    // MSB of tx is on the wire while enabled and not all bits have been clocked out
    assign bus.miso      = oe_q & (bit_cnt < 4'(READ_WIDTH)) & tx_q[READ_WIDTH-1];
    assign bus.miso_oe   = oe_q;
    assign bus.wr_vld    = wr_vld_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.rd_done   = rd_done_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed bench for spi_slave_regs: a frame-level register/event model plus a
// per-cycle checker of the strobes and the miso/miso_oe rules.
module tb_spi_slave_regs;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    spi_slave_regs_if bus ();
    spi_slave_regs dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] kind;   // 0 write, 1 read done, 2 frame error
        logic [2:0] addr;
        logic [7:0] data;
    } ev_t;

    int   tests = 0;
    int   fails = 0;
    int   n_wr = 0, n_rd = 0, n_err = 0;
    int   cs_hi_cnt = 0;
    ev_t  exp_q [$];
    logic [7:0] m_regs [8];
    bit         m_pend;
    logic [7:0] m_snap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_ev(input logic [1:0] kind, input logic [2:0] addr, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic xfer(input int n, input logic [15:0] val, output logic [15:0] rx);
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            bus.mosi = val[i];
            #50 bus.sclk = 1'b1;
            rx = {rx[14:0], bus.miso};
            #50 bus.sclk = 1'b0;
        end
        bus.mosi = 1'b0;
    endtask

    task automatic frame(input int n, input logic [15:0] val);
        logic [15:0] rx;
        bus.cs = 1'b0;
        #100 xfer(n, val, rx);
        #50;
        if (n == 12 && val[11]) begin
            m_regs[val[10:8]] = val[7:0];
            push_ev(2'd0, val[10:8], val[7:0]);
        end else if (n == 4 && !val[3]) begin
            m_pend = 1'b1;
            m_snap = m_regs[val[2:0]];
        end else begin
            push_ev(2'd2, 3'd0, 8'd0);
        end
        bus.cs = 1'b1;
        #300;
    endtask

    task automatic read_frame(input int n, output logic [15:0] rx);
        logic [15:0] expv;
        bus.cs = 1'b0;
        #100 check("oe_in_window", 32'(bus.miso_oe), 32'd1);
        check("read_pending", 32'(m_pend), 32'd1);
        xfer(n, 16'($urandom), rx);
        expv = '0;
        for (int i = 0; i < n; i++) expv = {expv[14:0], (i < 8) ? m_snap[7 - i] : 1'b0};
        check("read_bits", 32'(rx), 32'(expv));
        #50;
        if (n == 8) push_ev(2'd1, 3'd0, 8'd0);
        else        push_ev(2'd2, 3'd0, 8'd0);
        m_pend = 1'b0;
        bus.cs = 1'b1;
        #300;
    endtask

    // per-cycle output checker against the expected-event queue
    always @(negedge clk) begin
        int   np;
        ev_t  e;
        logic [1:0] act_kind;
        cs_hi_cnt = bus.cs ? cs_hi_cnt + 1 : 0;
        if (!bus.miso_oe) check("miso_zero_when_off", 32'(bus.miso), 32'd0);
        if (cs_hi_cnt > 4) check("oe_outside_cs", 32'(bus.miso_oe), 32'd0);
        np = int'(bus.wr_vld) + int'(bus.rd_done) + int'(bus.frame_err);
        if (np > 1) check("pulse_exclusive", 32'(np), 32'd1);
        if (np == 1) begin
            act_kind = bus.wr_vld ? 2'd0 : (bus.rd_done ? 2'd1 : 2'd2);
            if (act_kind == 2'd0) n_wr++;
            if (act_kind == 2'd1) n_rd++;
            if (act_kind == 2'd2) n_err++;
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'(act_kind) + 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", 32'(act_kind), 32'(e.kind));
                if (e.kind == 2'd0) begin
                    check("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
                    check("wr_data", 32'(bus.wr_data), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rx;
        bus.sclk = 1'b0;
        bus.cs   = 1'b1;
        bus.mosi = 1'b0;
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_pend = 1'b0;
        m_snap = 8'h00;

        #23;
        check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        check("rst_wr_data", 32'(bus.wr_data), 32'd0);
        check("rst_miso_oe", 32'(bus.miso_oe), 32'd0);
        check("rst_pulses", 32'({bus.wr_vld, bus.rd_done, bus.frame_err}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #102;

        // sclk toggling while cs is high must do nothing
        bus.mosi = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #50 bus.sclk = 1'b1;
            #50 bus.sclk = 1'b0;
        end
        bus.mosi = 1'b0;
        #200;

        frame(12, 16'hBA5);
        check("lit_wr_addr_3", 32'(bus.wr_addr), 32'd3);
        check("lit_wr_data_a5", 32'(bus.wr_data), 32'hA5);
        check("lit_n_wr_1", 32'(n_wr), 32'd1);

        frame(4, 16'h3);
        read_frame(8, rx);
        check("lit_read_a5", 32'(rx[7:0]), 32'hA5);
        check("lit_n_rd_1", 32'(n_rd), 32'd1);

        frame(4, 16'h5);
        read_frame(8, rx);
        check("lit_read_untouched", 32'(rx[7:0]), 32'h00);

        frame(7, 16'h7F);
        frame(12, 16'h3A5);
        check("lit_n_err_2", 32'(n_err), 32'd2);
        check("lit_n_wr_still_1", 32'(n_wr), 32'd1);
        frame(4, 16'h3);
        read_frame(8, rx);
        check("lit_regs_unchanged", 32'(rx[7:0]), 32'hA5);

        frame(4, 16'h3);
        read_frame(5, rx);
        check("lit_short_read_bits", 32'(rx[4:0]), 32'b10100);
        check("lit_n_err_3", 32'(n_err), 32'd3);
        frame(12, 16'h8FF);
        check("lit_wr_addr_0", 32'(bus.wr_addr), 32'd0);
        check("lit_wr_data_ff", 32'(bus.wr_data), 32'hFF);

        // reset in the middle of a write frame, released while cs is still low
        bus.cs = 1'b0;
        #100 xfer(6, 16'h2E, rx);
        rst_n = 1'b0;
        #30;
        check("midrst_wr_data", 32'(bus.wr_data), 32'd0);
        check("midrst_miso_oe", 32'(bus.miso_oe), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_pend = 1'b0;
        #20 xfer(6, 16'h25, rx);
        #50 bus.cs = 1'b1;
        #300;
        check("lit_midrst_n_wr", 32'(n_wr), 32'd2);
        check("lit_midrst_n_err", 32'(n_err), 32'd3);

        frame(4, 16'h3);
        read_frame(8, rx);
        check("lit_regfile_cleared", 32'(rx[7:0]), 32'h00);
        frame(12, 16'hC3C);
        check("lit_wr_addr_4", 32'(bus.wr_addr), 32'd4);
        check("lit_wr_data_3c", 32'(bus.wr_data), 32'h3C);
        frame(4, 16'h4);
        read_frame(8, rx);
        check("lit_read_3c", 32'(rx[7:0]), 32'h3C);

        #200;
        check("all_events_seen", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_slave_regs.md
SPI_SLAVE_REGS -- requirements
Module: spi_slave_regs

Interface
REQ-001 The block SHALL use these parameters:
- CMD_WIDTH, default 12: write-frame length in bits.
- READ_WIDTH, default 8: data width.
- ADDR_W, fixed as CMD_WIDTH-1-READ_WIDTH (3): address width.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: system clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- sclk, in, 1: SPI clock from the master; mode 0, idle low.
- cs, in, 1: chip select from the master, active-low.
- mosi, in, 1: serial data from the master, MSB first.
- miso, out, 1: serial data to the master, MSB first.
- miso_oe, out, 1: high while the block drives miso.
- wr_vld, out, 1: one-cycle pulse, register written.
- wr_addr, out, ADDR_W: address of the last write.
- wr_data, out, READ_WIDTH: data of the last write.
- rd_done, out, 1: one-cycle pulse, read-data frame completed.
- frame_err, out, 1: one-cycle pulse, malformed frame.

Function
REQ-003 The block SHALL pass sclk, cs and mosi through 2-flop synchronizers on clk and detect edges on the synchronized signals; clk SHALL be at least 8x the sclk frequency.
REQ-004 Frame formats SHALL be:
- Write frame: 12 bits, [11]=1, [10:8]=addr, [7:0]=data.
- Read-header frame: 4 bits, [3]=0, [2:0]=addr.
- Read-data frame: the following cs-low window, in which the block shifts out 8 bits.
REQ-005 The block SHALL contain an 8 x READ_WIDTH register file, all entries 0 after reset.
REQ-006 The state machine SHALL have the states IDLE, HDR, RD_PEND and RD_SHIFT.
REQ-007 In IDLE, a synchronized cs falling edge SHALL clear the bit counter and the shift register and move to HDR.
REQ-008 In HDR, on each synchronized sclk rising edge the block SHALL shift mosi into the LSB of the shift register and increment the bit counter; the counter SHALL saturate at 15.
REQ-009 On a synchronized cs rising edge in HDR:
- Count 12 with bit[11]=1: write reg[addr], update wr_addr/wr_data, pulse wr_vld in the next clk cycle, go to IDLE.
- Count 4 with bit[3]=0: latch addr, snapshot reg[addr] into the tx register, go to RD_PEND.
- Any other count or flag combination: pulse frame_err, go to IDLE, with no register change.
REQ-010 In RD_PEND, a cs falling edge SHALL move to RD_SHIFT and assert miso_oe.
- miso SHALL present tx[7] in the same cycle that miso_oe rises.
- Any mosi content in this frame SHALL be ignored.
REQ-011 In RD_SHIFT, each sclk falling edge SHALL advance miso to the next lower bit.
- Each sclk rising edge SHALL increment the bit counter.
- After 8 rising edges, miso SHALL be 0.
REQ-012 On a cs rising edge in RD_SHIFT, the block SHALL deassert miso_oe and go to IDLE.
- It SHALL pulse rd_done if the count equals 8.
- Otherwise it SHALL pulse frame_err.
REQ-013 miso SHALL be 0 whenever miso_oe is 0.
REQ-014 The rd_done, wr_vld and frame_err pulses SHALL be exactly 1 clk wide and mutually exclusive.
REQ-015 A write to the address latched in RD_PEND SHALL NOT be possible, because a write frame cannot occur before the read-data frame. The snapshot taken at the header SHALL be the value returned.
REQ-016 sclk edges while cs is high SHALL be ignored in all states.

Reset
REQ-017 On rst_n low, the block SHALL asynchronously force:
- state to IDLE;
- all counters, shift and tx registers, and the register file to 0;
- miso, miso_oe, wr_vld, rd_done, frame_err, wr_addr and wr_data to 0;
- all synchronizer flops to 0, except cs flops, which SHALL be forced to 1.
REQ-018 Reset released while cs is low SHALL NOT start a frame. The block SHALL wait for a full cs high-then-low sequence.
REQ-019 Reset asserted mid-frame SHALL discard the frame, with no wr_vld or frame_err.

Verification
REQ-020 The bench SHALL cover at least these scenarios:
- Write frame 0xBA5 (addr 3, data 0xA5) -> one wr_vld pulse, wr_addr=3, wr_data=0xA5, frame_err=0.
- Write 0xBA5, then header 0x3, then an 8-clock read frame -> miso bits 1,0,1,0,0,1,0,1 sampled on sclk rising edges, rd_done=1 once, miso_oe high only inside the cs window.
- Read of untouched addr 5 (header 0x5) after reset -> miso all 0, rd_done pulse.
- 7-bit frame, then a 12-bit frame with bit[11]=0 -> frame_err pulses twice, no wr_vld, register file unchanged.
- Read-data frame of 5 clocks -> frame_err pulse, return to IDLE; the next write 0x8FF is accepted (wr_addr=0, wr_data=0xFF).
- rst_n pulsed after 6 bits of a write frame -> no wr_vld or frame_err; the next full write frame succeeds.
